and_result_tx: RTL and testbench

AND_RESULT_TX -- requirements
Module: and_result_tx

---
 rtl/and_tx_pkg.sv | 18 +
 rtl/and_result_tx_if.sv | 17 +
 rtl/and_tx_baud.sv | 38 +++
 rtl/and_result_tx.sv | 130 +++++++++++++
 tb/tb_and_result_tx.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/and_tx_pkg.sv
// rtl/and_tx_pkg.sv - shared types and helpers for the AND-result serial transmitter
package and_tx_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Width of the baud counter that counts 0..clks-1
  function automatic int baud_w(input int clks);
    return (clks < 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/and_result_tx_if.sv
// rtl/and_result_tx_if.sv - operand/request inputs and serial/status outputs of the transmitter
interface and_result_tx_if;

  logic [7:0] a;
  logic [7:0] b;
  logic       start;
  logic       tx;
  logic       busy;
  logic       done;

  // Requester side: drives operands and start, observes the line
  modport master (output a, b, start, input tx, busy, done);

  // Transmitter side
  modport slave (input a, b, start, output tx, busy, done);

endinterface

// File: rtl/and_tx_baud.sv
// rtl/and_tx_baud.sv - per-bit baud counter with last-cycle tick
module and_tx_baud
  import and_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  output logic tick
);

  localparam int            W    = baud_w(CLKS_PER_BIT);
  localparam logic [W-1:0]  LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Count up within a bit; wrap on the last cycle so the next bit starts at 0
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (reload || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/and_result_tx.sv
// rtl/and_result_tx.sv - serialises a&b as a UART-style frame with optional even parity
module and_result_tx
  import and_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic            clk,
  input  logic            reset,
  and_result_tx_if.slave  bus
);

  tx_state_e  state_q;
  tx_state_e  state_d;
  logic [7:0] data_q;
  logic [7:0] data_d;
  logic [2:0] idx_q;
  logic [2:0] idx_d;
  logic       tx_q;
  logic       tx_d;
  logic       busy_q;
  logic       busy_d;
  logic       done_q;
  logic       done_d;
  logic       tick;
  logic       reload;

  // Counter is held at zero while idle so the START bit gets a full period
  assign reload = (state_q == ST_IDLE);

  and_tx_baud #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .reload (reload),
    .tick   (tick)
  );

  // State, data and bit-index registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic; operands are captured only on acceptance in IDLE
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_START;
          data_d  = bus.a & bus.b;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so registered outputs line up with state_q
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != ST_IDLE);
    unique case (state_d)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_d[idx_d];
      ST_PARITY: tx_d = ^data_d;
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  // Registered outputs keep the line glitch-free and isolated from inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_and_result_tx.sv
// tb/tb_and_result_tx.sv - directed self-checking bench for and_result_tx
module tb_and_result_tx;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  and_result_tx_if if0 ();
  and_result_tx_if if1 ();

  and_result_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  and_result_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_tx(input int w);
    return (w == 0) ? if0.tx : if1.tx;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 0) ? if0.busy : if1.busy;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 0) ? if0.done : if1.done;
  endfunction

  task automatic set_ab(input int w, input logic [7:0] av, input logic [7:0] bv);
    if (w == 0) begin
      if0.a = av; if0.b = bv;
    end else begin
      if1.a = av; if1.b = bv;
    end
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 0) if0.start = v;
    else        if1.start = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected frame bits: [0]=start, [8:1]=data LSB first, then parity/stop
  function automatic logic [10:0] mk(input logic [7:0] d, input bit par);
    logic [10:0] f;
    f       = '1;
    f[0]    = 1'b0;
    f[8:1]  = d;
    if (par) f[9] = ^d;
    return f;
  endfunction

  task automatic chk_idle(input int w, input string tag);
    chk({tag, "_tx"},   32'(get_tx(w)),   32'd1);
    chk({tag, "_busy"}, 32'(get_busy(w)), 32'd0);
    chk({tag, "_done"}, 32'(get_done(w)), 32'd0);
  endtask

  // Called just after the acceptance edge; ends just after the edge that ends STOP.
  // ev_kind: 0 none, 1 zero operands + start pulse, 2 a=0x55, 3 reset, 4 drop start
  task automatic run_frame(input int w, input logic [10:0] fr, input int nb,
                           input int ev_cyc, input int ev_kind, input string name);
    for (int i = 0; i < 4 * nb; i++) begin
      chk($sformatf("%s_c%0d_tx", name, i),   32'(get_tx(w)),   32'(fr[i / 4]));
      chk($sformatf("%s_c%0d_busy", name, i), 32'(get_busy(w)), 32'd1);
      chk($sformatf("%s_c%0d_done", name, i), 32'(get_done(w)), 32'd0);
      if (i == ev_cyc) begin
        case (ev_kind)
          1: begin set_ab(w, 8'h00, 8'h00); set_start(w, 1'b1); end
          2: begin
            if (w == 0) if0.a = 8'h55;
            else        if1.a = 8'h55;
          end
          3: begin
            reset = 1'b1;
            #1;
            chk_idle(w, {name, "_abort"});
            return;
          end
          4: set_start(w, 1'b0);
          default: ;
        endcase
      end
      if (ev_kind == 1 && i == ev_cyc + 1) set_start(w, 1'b0);
      step();
    end
    chk({name, "_end_done"}, 32'(get_done(w)), 32'd1);
    chk({name, "_end_busy"}, 32'(get_busy(w)), 32'd0);
    chk({name, "_end_tx"},   32'(get_tx(w)),   32'd1);
  endtask

  task automatic pulse_start(input int w);
    set_start(w, 1'b1);
    step();
    set_start(w, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    set_ab(0, 8'h00, 8'h00); set_start(0, 1'b0);
    set_ab(1, 8'h00, 8'h00); set_start(1, 1'b0);

    // Reset state
    repeat (3) step();
    chk_idle(0, "rst0");
    chk_idle(1, "rst1");
    reset = 1'b0;
    step();
    chk_idle(0, "post_rst0");

    // No parity: 0xF0 & 0x3C = 0x30
    set_ab(0, 8'hF0, 8'h3C);
    pulse_start(0);
    run_frame(0, mk(8'h30, 1'b0), 10, -1, 0, "t1");
    step();
    chk_idle(0, "t1_after");

    // Even parity: 0xFF & 0x07 = 0x07, parity 1
    set_ab(1, 8'hFF, 8'h07);
    pulse_start(1);
    run_frame(1, mk(8'h07, 1'b1), 11, -1, 0, "t2");
    step();
    chk_idle(1, "t2_after");

    // Operand change and start pulse mid-frame are ignored
    set_ab(0, 8'h5A, 8'hFF);
    pulse_start(0);
    run_frame(0, mk(8'h5A, 1'b0), 10, 10, 1, "t3");
    step();
    chk_idle(0, "t3_after1");
    step();
    chk_idle(0, "t3_after2");

    // Held start: back-to-back frames, second captures a changed during the first
    set_ab(0, 8'hAA, 8'hFF);
    set_start(0, 1'b1);
    step();
    run_frame(0, mk(8'hAA, 1'b0), 10, 5, 2, "t4a");
    step();
    run_frame(0, mk(8'h55, 1'b0), 10, 2, 4, "t4b");
    step();
    chk_idle(0, "t4_after");

    // Reset at cycle 15 aborts without done; next frame is clean
    set_ab(0, 8'hC3, 8'hFF);
    pulse_start(0);
    run_frame(0, mk(8'hC3, 1'b0), 10, 15, 3, "t5");
    step();
    chk_idle(0, "t5_held");
    reset = 1'b0;
    step();
    chk_idle(0, "t5_release");
    set_ab(0, 8'h81, 8'hFF);
    pulse_start(0);
    run_frame(0, mk(8'h81, 1'b0), 10, -1, 0, "t6");
    step();
    chk_idle(0, "t6_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
